clk_phase_gen: RTL

Parametrised N-phase gated clock generator. It distributes `clk_in` pulses round-robin across `NUM_PHASES` output clocks, and each phase owns a programmable number of consecutive `clk_in` pulses. Outputs are non-overlapping and glitch-free, and start/stop is clean on round boundaries. It feeds multi-phase sequencing logic (time-sliced datapaths, multi-phase sampling) from a single source clock.

---
 rtl/clk_phase_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/clk_phase_gen.sv
// clk_phase_gen: N-phase gated clock generator. It hands clk_in pulses round-robin
// to NUM_PHASES outputs, giving each phase a programmable number of consecutive pulses.
// All state moves on the falling edge of clk_in, so the gates only change while clk_in
// is low and the AND-gated phase clocks stay glitch-free.
module clk_phase_gen #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk_in,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [CNT_W-1:0]              slot_len,
  output logic [NUM_PHASES-1:0]         clk_ph,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          round_done,
  output logic                          running
);

  localparam int unsigned IDX_W = $clog2(NUM_PHASES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  logic [1:0]            r_state;
  logic [NUM_PHASES-1:0] r_gate_q;
  logic [CNT_W-1:0]      r_slot_cnt;
  logic [CNT_W-1:0]      r_len_q;
  logic [IDX_W-1:0]      r_phase_idx;
  logic                  r_round_done;
  logic                  r_running;

  logic [1:0]            w_state_nxt;
  logic [NUM_PHASES-1:0] w_gate_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_len_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_rd_nxt;
  logic [CNT_W-1:0]      w_len_sel;
  logic                  w_slot_end;
  logic                  w_wrap;

  // Slot length with zero promoted to one; slot end and round wrap detection.
  assign w_len_sel  = (slot_len == '0) ? CNT_W'(1) : slot_len;
  assign w_slot_end = (r_slot_cnt >= (r_len_q - CNT_W'(1)));
  assign w_wrap     = w_slot_end && (r_phase_idx == LAST_IDX);

  // Next-state logic: slot counting, phase rotation and start/stop on round boundaries.
  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = r_gate_q;
    w_cnt_nxt   = r_slot_cnt;
    w_len_nxt   = r_len_q;
    w_idx_nxt   = r_phase_idx;
    w_rd_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gate_nxt = '0;
        if (en) begin
          w_state_nxt = ST_RUN;
          w_gate_nxt  = NUM_PHASES'(1);
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_len_nxt   = w_len_sel;
        end
      end
      ST_RUN, ST_FINISH: begin
        if (!w_slot_end) begin
          w_cnt_nxt = r_slot_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt  = '0;
          w_gate_nxt = {r_gate_q[NUM_PHASES-2:0], r_gate_q[NUM_PHASES-1]};
          if (w_wrap) begin
            w_idx_nxt = '0;
            w_rd_nxt  = 1'b1;
            w_len_nxt = w_len_sel;
          end else begin
            w_idx_nxt = r_phase_idx + IDX_W'(1);
          end
        end
        // A stop request only takes effect at the wrap, so a started round always completes.
        if (en) begin
          w_state_nxt = ST_RUN;
        end else if (w_wrap) begin
          w_state_nxt = ST_IDLE;
          w_gate_nxt  = '0;
        end else begin
          w_state_nxt = ST_FINISH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gate_nxt  = '0;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State registers on the falling edge so gates settle while clk_in is low.
  always_ff @(negedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_gate_q     <= '0;
      r_slot_cnt   <= '0;
      r_len_q      <= CNT_W'(1);
      r_phase_idx  <= '0;
      r_round_done <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gate_q     <= w_gate_nxt;
      r_slot_cnt   <= w_cnt_nxt;
      r_len_q      <= w_len_nxt;
      r_phase_idx  <= w_idx_nxt;
      r_round_done <= w_rd_nxt;
      r_running    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign clk_ph     = {NUM_PHASES{clk_in}} & r_gate_q;
  assign phase_idx  = r_phase_idx;
  assign round_done = r_round_done;
  assign running    = r_running;

endmodule
